answer_checker: RTL and testbench

- Input side of the binary-count game. Conditions the player's submit button and answer switches, then compares the captured answer with the current target.
- Maintains score and lives, and requests the next target from the round generator.
- Sits between the top-level ui_in pins and the game/display logic. The top-level wrapper derives rst = ~rst_n.

---
 rtl/game_pkg.sv | 20 ++
 rtl/debounce_sync.sv | 60 ++++++
 rtl/answer_checker.sv | 145 ++++++++++++++
 tb/tb_answer_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared FSM encoding, widths and score helper for the answer checker
package game_pkg;

    localparam int SCORE_W = 8;
    localparam int LIVES_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CHECK,
        REPORT,
        GAME_OVER
    } state_e;

    // Score increments but never wraps past all-ones.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-FF synchronizer, debounce counter and rising-edge pulse for one button
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter runs only while the synchronized input disagrees with the settled level;
    // the toggle edge also produces the registered rise pulse.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer chain plus debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/answer_checker.sv
// rtl/answer_checker.sv - captures the player's answer, scores it and manages lives and rounds
module answer_checker
    import game_pkg::*;
#(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_LIVES       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_raw,
    input  logic [WIDTH-1:0]   sw_raw,
    input  logic [WIDTH-1:0]   target,
    input  logic               target_valid,
    output logic               next_req,
    output logic               result_valid,
    output logic               correct,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

    logic               btn_level;
    logic               press;

    logic [WIDTH-1:0]   sw_s1_q;
    logic [WIDTH-1:0]   sw_s2_q;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ans_q, ans_d;
    logic               correct_q, correct_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               next_req_q, next_req_d;
    logic               result_valid_q, result_valid_d;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw),
        .level(btn_level),
        .rise (press)
    );

    // Switches only need metastability protection; they are sampled on a debounced press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_raw;
            sw_s2_q <= sw_s1_q;
        end
    end

    // Round sequencing, scoring and lives bookkeeping.
    always_comb begin
        state_d        = state_q;
        ans_d          = ans_q;
        correct_d      = correct_q;
        score_d        = score_q;
        lives_d        = lives_q;
        next_req_d     = 1'b0;
        result_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (target_valid) state_d = ARMED;
            end
            ARMED: begin
                // Losing the target wins over a coincident press.
                if (!target_valid) begin
                    state_d = IDLE;
                end else if (press) begin
                    ans_d   = sw_s2_q;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                result_valid_d = 1'b1;
                correct_d      = (ans_q == target);
                if (ans_q == target) begin
                    score_d = sat_inc(score_q);
                    state_d = REPORT;
                end else if (lives_q <= LIVES_ONE) begin
                    lives_d = '0;
                    state_d = GAME_OVER;
                end else begin
                    lives_d = lives_q - 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // Wait for release so a held button cannot feed the next round.
                if (!btn_level) begin
                    next_req_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            GAME_OVER: begin
                if (press) begin
                    score_d    = '0;
                    lives_d    = LIVES_INIT;
                    correct_d  = 1'b0;
                    next_req_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ans_q          <= '0;
            correct_q      <= 1'b0;
            score_q        <= '0;
            lives_q        <= LIVES_INIT;
            next_req_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ans_q          <= ans_d;
            correct_q      <= correct_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            next_req_q     <= next_req_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign next_req     = next_req_q;
    assign result_valid = result_valid_q;
    assign correct      = correct_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign game_over    = (state_q == GAME_OVER);

endmodule

// File: tb/tb_answer_checker.sv
// tb/tb_answer_checker.sv - self-checking bench for answer_checker against a round-level game model
module tb_answer_checker;

    localparam int DC = 4;
    localparam int W  = 7;
    localparam int ML = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_raw = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] target = '0;
    logic         target_valid = 1'b0;
    logic         next_req;
    logic         result_valid;
    logic         correct;
    logic [7:0]   score;
    logic [2:0]   lives;
    logic         game_over;

    int tests = 0;
    int fails = 0;
    int rv_cnt = 0;
    int nr_cnt = 0;

    int m_score = 0;
    int m_lives = ML;
    bit m_over  = 1'b0;

    answer_checker #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC),
        .MAX_LIVES(ML)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .sw_raw      (sw_raw),
        .target      (target),
        .target_valid(target_valid),
        .next_req    (next_req),
        .result_valid(result_valid),
        .correct     (correct),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid === 1'b1) rv_cnt++;
        if (next_req === 1'b1) nr_cnt++;
    end

    task automatic model_reset();
        m_score = 0;
        m_lives = ML;
        m_over  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_raw = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    // One full round: set switches, press, check the result, optionally release and check next_req.
    task automatic submit(input logic [W-1:0] tgt, input logic [W-1:0] ans, input int hold, input bit rel);
        int lat;
        int nr0;
        int rv0;
        bit exp_c;
        target = tgt;
        sw_raw = ans;
        repeat (4) @(negedge clk);
        exp_c = (tgt == ans);
        if (exp_c) begin
            if (m_score < 255) m_score++;
        end else begin
            m_lives--;
            if (m_lives == 0) m_over = 1'b1;
        end
        nr0 = nr_cnt;
        rv0 = rv_cnt;
        btn_raw = 1'b1;
        lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat != DC + 4) begin
            fails++;
            $display("FAIL latency: got %0d cycles, expected %0d", lat, DC + 4);
        end
        tests++;
        if (correct !== exp_c) begin
            fails++;
            $display("FAIL correct: got %b, expected %b (tgt=%0d ans=%0d)", correct, exp_c, tgt, ans);
        end
        tests++;
        if (score !== 8'(m_score)) begin
            fails++;
            $display("FAIL score: got %0d, expected %0d", score, m_score);
        end
        tests++;
        if (lives !== 3'(m_lives)) begin
            fails++;
            $display("FAIL lives: got %0d, expected %0d", lives, m_lives);
        end
        tests++;
        if (game_over !== m_over) begin
            fails++;
            $display("FAIL game_over: got %b, expected %b", game_over, m_over);
        end
        @(negedge clk);
        tests++;
        if (result_valid !== 1'b0) begin
            fails++;
            $display("FAIL result_valid_pulse: got %b, expected 0", result_valid);
        end
        repeat (hold) @(negedge clk);
        if (!rel) return;
        btn_raw = 1'b0;
        if (m_over) begin
            repeat (20) @(negedge clk);
            tests++;
            if (nr_cnt != nr0 || game_over !== 1'b1) begin
                fails++;
                $display("FAIL over_hold: next_req pulses %0d (expected 0), game_over %b (expected 1)", nr_cnt - nr0, game_over);
            end
        end else begin
            lat = 0;
            while (next_req !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            tests++;
            if (lat >= 40) begin
                fails++;
                $display("FAIL next_req_timeout: waited %0d cycles, expected a pulse", lat);
            end
            repeat (3) @(negedge clk);
            tests++;
            if (nr_cnt - nr0 != 1 || rv_cnt - rv0 != 1) begin
                fails++;
                $display("FAIL round_pulses: next_req %0d result_valid %0d, expected 1 and 1", nr_cnt - nr0, rv_cnt - rv0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({next_req, result_valid, correct, score, lives, game_over} !== {1'b0, 1'b0, 1'b0, 8'd0, 3'(ML), 1'b0}) begin
            fails++;
            $display("FAIL reset_values: nr=%b rv=%b c=%b score=%0d lives=%0d go=%b, expected 0 0 0 0 %0d 0",
                     next_req, result_valid, correct, score, lives, game_over, ML);
        end
        rst = 1'b0;
        model_reset();
        target_valid = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_correct();
        submit(7'd37, 7'b0100101, 3, 1'b1);
    endtask

    task automatic test_glitch();
        int rv0;
        rv0 = rv_cnt;
        target = 7'd11;
        sw_raw = 7'd11;
        repeat (4) @(negedge clk);
        btn_raw = 1'b1;
        repeat (2) @(negedge clk);
        btn_raw = 1'b0;
        repeat (15) @(negedge clk);
        tests++;
        if (rv_cnt != rv0 || score !== 8'(m_score)) begin
            fails++;
            $display("FAIL glitch: result pulses %0d score %0d, expected 0 and %0d", rv_cnt - rv0, score, m_score);
        end
        submit(7'd11, 7'd11, 2, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] tgt;
        logic [W-1:0] ans;
        logic [W-1:0] flip;
        for (int i = 0; i < 16; i++) begin
            tgt = W'($urandom);
            if (m_lives <= 1 || $urandom_range(0, 2) != 0) begin
                ans = tgt;
            end else begin
                flip = W'($urandom_range(1, 127));
                ans = tgt ^ flip;
            end
            submit(tgt, ans, int'($urandom_range(0, 12)), 1'b1);
        end
    endtask

    task automatic test_game_over();
        int nr0;
        int lat;
        do_reset();
        for (int i = 0; i < 3; i++) submit(7'd5, 7'd4, 1, 1'b1);
        nr0 = nr_cnt;
        btn_raw = 1'b1;
        lat = 0;
        while (next_req !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        model_reset();
        tests++;
        if (lat >= 40 || score !== 8'd0 || lives !== 3'(ML) || game_over !== 1'b0 || correct !== 1'b0) begin
            fails++;
            $display("FAIL restart: wait=%0d score=%0d lives=%0d go=%b c=%b, expected pulse 0 %0d 0 0",
                     lat, score, lives, game_over, correct, ML);
        end
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);
        tests++;
        if (nr_cnt - nr0 != 1) begin
            fails++;
            $display("FAIL restart_next_req: got %0d pulses, expected 1", nr_cnt - nr0);
        end
    endtask

    task automatic test_abort();
        int rv0;
        rv0 = rv_cnt;
        target = 7'd9;
        sw_raw = 7'd9;
        target_valid = 1'b0;
        repeat (3) @(negedge clk);
        btn_raw = 1'b1;
        repeat (12) @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);
        target_valid = 1'b1;
        repeat (3) @(negedge clk);
        target_valid = 1'b0;
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (12) @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);
        tests++;
        if (rv_cnt != rv0) begin
            fails++;
            $display("FAIL abort_idle: got %0d results, expected 0", rv_cnt - rv0);
        end
        target_valid = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw = 1'b1;
        repeat (6) @(negedge clk);
        target_valid = 1'b0;
        repeat (10) @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);
        tests++;
        if (rv_cnt != rv0 || score !== 8'(m_score)) begin
            fails++;
            $display("FAIL abort_same_cycle: got %0d results score %0d, expected 0 and %0d", rv_cnt - rv0, score, m_score);
        end
        target_valid = 1'b1;
        repeat (2) @(negedge clk);
        submit(7'd9, 7'd9, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int rv0;
        int nr0;
        submit(7'd21, 7'd21, 1, 1'b1);
        btn_raw = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (score !== 8'd0 || lives !== 3'(ML) || correct !== 1'b0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_debounce: score=%0d lives=%0d c=%b rv=%b, expected 0 %0d 0 0", score, lives, correct, result_valid, ML);
        end
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        submit(7'd50, 7'd50, 2, 1'b0);
        rv0 = rv_cnt;
        nr0 = nr_cnt;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if (score !== 8'd0 || lives !== 3'(ML) || correct !== 1'b0 || next_req !== 1'b0 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL reset_report: score=%0d lives=%0d c=%b nr=%b go=%b, expected 0 %0d 0 0 0", score, lives, correct, next_req, game_over, ML);
        end
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        tests++;
        if (nr_cnt != nr0 || rv_cnt != rv0) begin
            fails++;
            $display("FAIL reset_no_pending: next_req %0d result_valid %0d, expected 0 and 0", nr_cnt - nr0, rv_cnt - rv0);
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] tgt;
        do_reset();
        for (int i = 0; i < 255; i++) begin
            tgt = W'($urandom);
            submit(tgt, tgt, 0, 1'b1);
        end
        tgt = W'($urandom);
        submit(tgt, tgt, 0, 1'b1);
        tests++;
        if (score !== 8'd255) begin
            fails++;
            $display("FAIL saturation: got %0d, expected 255", score);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_glitch();
        test_random();
        test_game_over();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
